lsu_mem_stage: RTL
==================

// Module: lsu_mem_stage
// PURPOSE
//  RV32I load/store unit for the MEM stage; sits between the EX/MEM register and the MEM/WB register.
//  Drives a single-outstanding data-memory bus with req/ack handshake.
//  Aligns store data and builds byte enables; extracts and sign/zero-extends load data into Data_Out.
//  Raises StallM while an access is in flight so the front of the pipeline holds.
// PARAMETERS
//  AW        32   data-memory byte-address width; dmem_addr is word-aligned, low 2 bits forced 0
//  TIMEOUT   255  max cycles in BUSY without dmem_ack before the access is aborted (1..255)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  MemReadM     in   1   load in MEM stage
//  MemWriteM    in   1   store in MEM stage
//  Funct3M      in   3   access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW 000/001/010)
//  ALUResultM   in   32  effective byte address
//  WriteDataM   in   32  store source data (rs2)
//  Data_Out     out  32  extended load data, valid in DONE; sampled by MEM/WB register
//  StallM       out  1   hold IF/ID/EX/MEM registers
//  BusErrM      out  1   one-cycle pulse: access timed out
//  dmem_req     out  1   request valid (registered)
//  dmem_we      out  1   1 = write
//  dmem_addr    out  AW  word-aligned address
//  dmem_be      out  4   byte enables (writes); 4'b1111 on reads
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_ack     in   1   completes the request; dmem_rdata valid in the same cycle
//  dmem_rdata   in   32  read word
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; Data_Out=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0,
//   BusErrM=0, timeout counter=0. Reset during BUSY drops dmem_req at once; no completion follows.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: access = MemReadM|MemWriteM. StallM = access (combinational). On access: capture addr/be/wdata/we/funct3/addr[1:0]
//    into bus registers, dmem_req<=1, counter<=0, go BUSY. MemWriteM has priority if both are set (treated as store).
//   BUSY: StallM=1; dmem_req held with stable addr/be/wdata/we. On dmem_ack: dmem_req<=0; loads register extended
//    rdata into Data_Out; go DONE. Without ack: counter++; when counter==TIMEOUT-1: dmem_req<=0, Data_Out<=0,
//    BusErrM<=1 (for the DONE cycle only), go DONE. An ack in that same cycle wins (normal completion).
//   DONE: StallM=0; pipeline advances at this edge and MEM/WB captures Data_Out; go IDLE unconditionally.
//  Min latency 3 cycles per access (request edge, ack cycle, DONE); StallM is high for 2 of them with a zero-wait ack.
//  Data_Out holds its value across stores and idle cycles.
//  Store lanes: SB be=4'b0001<<a[1:0], wdata={4{b}}; SH be=4'b0011<<{a[1],1'b0}, wdata={2{h}}; SW be=4'b1111.
//  Load extract: byte rdata[8*a[1:0]+:8], half rdata[16*a[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  Undefined Funct3M (011, 110, 111) is handled as a word access.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, issue no bus request. The FSM goes
//   IDLE->DONE directly, with StallM=0 in IDLE (no stall), and MisalignM (extra out, 1 bit, reset 0) pulses in DONE.
//   Data_Out is not updated. The access is dropped.
//  Not defined: no MisalignM port; misaligned accesses proceed with a[0] ignored for halfwords and a[1:0] for words.
// STRUCTURE
//  Package riscv_pkg: FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW constants; lsu_state_t enum {IDLE,BUSY,DONE}.
//  Sub-module lsu_align (combinational):
//   - store side: be and wdata from funct3/a[1:0];
//   - load side: extract and extend from rdata/funct3/a[1:0].
//  The FSM and timeout counter live in lsu_mem_stage.
// TESTING
//  1. SW addr 0x104, data 0xDEADBEEF, ack 1 cycle after req -> be=1111, dmem_addr=0x104, StallM high 2 cycles, then DONE.
//  2. LB addr 0x203, rdata 0x80xxxxxx -> Data_Out=0xFFFFFF80. Same address with LBU -> 0x00000080.
//  3. SH addr 0x06, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD. LH addr 0x06, rdata 0x8001xxxx -> Data_Out=0xFFFF8001.
//  4. LW with ack never asserted, TIMEOUT=4 -> req drops after 4 BUSY cycles, BusErrM pulses 1 cycle, Data_Out=0.
//  5. rst_n low mid-BUSY -> dmem_req=0 and StallM=0 immediately; no Data_Out update after release.
//  6. MISALIGN_TRAP_EN defined, LW addr 0x102 -> no dmem_req, MisalignM pulses, StallM stays 0.
//     Not defined -> access at 0x100.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// MEM-stage FSM states, access-size decode and alignment helpers.
package riscv_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Load size; undefined encodings fall back to a word access.
    function automatic lsu_size_t ld_size(input logic [2:0] f3);
        lsu_size_t s;
        case (f3)
            FUNCT3_LB, FUNCT3_LBU: s = SZ_B;
            FUNCT3_LH, FUNCT3_LHU: s = SZ_H;
            default:               s = SZ_W;
        endcase
        return s;
    endfunction

    // Store size; anything that is not SB/SH is treated as a word store.
    function automatic lsu_size_t st_size(input logic [2:0] f3);
        lsu_size_t s;
        case (f3)
            FUNCT3_SB: s = SZ_B;
            FUNCT3_SH: s = SZ_H;
            default:   s = SZ_W;
        endcase
        return s;
    endfunction

    // True when the byte offset is not naturally aligned for the access size.
    function automatic logic is_misaligned(input logic is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
        lsu_size_t s;
        logic      m;
        s = is_store ? st_size(f3) : ld_size(f3);
        case (s)
            SZ_H:    m = off[0];
            SZ_W:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
// Store side: byte enables and lane-replicated write data from funct3/offset.
// Load side: byte/half extraction from the read word with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store lane steering: low bits of the offset below the access size are ignored.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size(st_funct3))
            SZ_B: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be    = 4'b0011 << {st_off[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

    // Load extraction and extension from the addressed lane.
    always_comb begin
        byte_s  = ld_rdata[{ld_off, 3'b000} +: 8];
        half_s  = ld_rdata[{ld_off[1], 4'b0000} +: 16];
        ld_data = ld_rdata;
        case (ld_funct3)
            FUNCT3_LB:  ld_data = {{24{byte_s[7]}}, byte_s};
            FUNCT3_LH:  ld_data = {{16{half_s[15]}}, half_s};
            FUNCT3_LBU: ld_data = {24'h000000, byte_s};
            FUNCT3_LHU: ld_data = {16'h0000, half_s};
            default:    ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I MEM-stage load/store unit with a single-outstanding req/ack data bus.
// IDLE -> BUSY -> DONE -> IDLE; StallM holds the front of the pipeline while
// the access is in flight, BusErrM pulses in DONE when the access times out.
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word accesses are
// dropped without a bus request and MisalignM pulses in DONE instead.
module lsu_mem_stage
    import riscv_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    input  logic [2:0]    Funct3M,
    input  logic [31:0]   ALUResultM,
    input  logic [31:0]   WriteDataM,
    output logic [31:0]   Data_Out,
    output logic          StallM,
    output logic          BusErrM,
`ifdef MISALIGN_TRAP_EN
    output logic          MisalignM,
`endif
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ack,
    input  logic [31:0]   dmem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state_r;
    lsu_state_t  state_nx_s;
    logic [7:0]  cnt_r;
    logic [2:0]  funct3_r;
    logic [1:0]  off_r;
    logic        access_s;
    logic        is_store_s;
    logic        trap_s;
    logic        timeout_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_data_s;

    assign access_s   = MemReadM | MemWriteM;
    assign is_store_s = MemWriteM;
    assign timeout_s  = (cnt_r == CNT_LAST);

`ifdef MISALIGN_TRAP_EN
    assign trap_s = access_s & is_misaligned(is_store_s, Funct3M, ALUResultM[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    lsu_align u_align (
        .st_funct3 (Funct3M),
        .st_off    (ALUResultM[1:0]),
        .st_data   (WriteDataM),
        .st_be     (st_be_s),
        .st_wdata  (st_wdata_s),
        .ld_funct3 (funct3_r),
        .ld_off    (off_r),
        .ld_rdata  (dmem_rdata),
        .ld_data   (ld_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; an ack in the timeout cycle is a normal completion.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (access_s) begin
                    state_nx_s = trap_s ? DONE : BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (dmem_ack || timeout_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Stall output: the IDLE term must be combinational so the access cycle itself holds.
    always_comb begin
        StallM = 1'b0;
        case (state_r)
            IDLE:    StallM = access_s & ~trap_s;
            BUSY:    StallM = 1'b1;
            DONE:    StallM = 1'b0;
            default: StallM = 1'b0;
        endcase
    end

    // Bus request registers and timeout counter; request fields stay stable through BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0000_0000;
            funct3_r   <= 3'b000;
            off_r      <= 2'b00;
            cnt_r      <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (access_s && !trap_s) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store_s;
                        dmem_addr  <= {ALUResultM[AW-1:2], 2'b00};
                        dmem_be    <= is_store_s ? st_be_s : 4'b1111;
                        dmem_wdata <= st_wdata_s;
                        funct3_r   <= Funct3M;
                        off_r      <= ALUResultM[1:0];
                        cnt_r      <= 8'd0;
                    end
                end
                BUSY: begin
                    if (dmem_ack || timeout_s) begin
                        dmem_req <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

    // Load result and bus-error pulse; Data_Out holds across stores and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Data_Out <= 32'h0000_0000;
            BusErrM  <= 1'b0;
        end else begin
            BusErrM <= (state_r == BUSY) && !dmem_ack && timeout_s;
            if (state_r == BUSY) begin
                if (dmem_ack) begin
                    if (!dmem_we) begin
                        Data_Out <= ld_data_s;
                    end
                end else if (timeout_s) begin
                    Data_Out <= 32'h0000_0000;
                end
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment pulse, high only in the DONE cycle of a dropped access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MisalignM <= 1'b0;
        end else begin
            MisalignM <= (state_r == IDLE) && trap_s;
        end
    end
`endif

endmodule
